gate_eval_arbiter: RTL and testbench

- Time-shares one registered two-stage evaluation unit among NUM_REQ requesters.
- Unit computes, bitwise over WIDTH bits: mid = a & b; and3 = mid & c; mix = mid | a.
- Round-robin arbiter and 3-state sequencer; valid/ready on each requester port and on the single response port.
- One operation in flight at a time.

---
 rtl/gate_eval_arbiter.sv | 129 ++++++++++++
 tb/tb_gate_eval_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_eval_arbiter.sv
// Round-robin front end that time-shares one two-stage bitwise evaluation unit
// (and3 = a&b&c, mix = (a&b)|a) among NUM_REQ requesters, one operation in flight.
module gate_eval_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_and3,
  output logic [WIDTH-1:0]         rsp_mix,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Handshakes: a requester transfer happens when req_valid[i] && req_ready[i];
  // the response transfers when rsp_valid && rsp_ready. Producers never wait on ready.

  logic [1:0]         r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_id_cap;
  logic [WIDTH-1:0]   r_a_cap;
  logic [WIDTH-1:0]   r_c_cap;
  logic [WIDTH-1:0]   r_mid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [WIDTH-1:0]   r_rsp_and3;
  logic [WIDTH-1:0]   r_rsp_mix;

  logic               w_found;
  logic [ID_W-1:0]    w_winner;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [ID_W-1:0]    w_next_ptr;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_c;
  int                 w_idx;

  // Walk k = 0..NUM_REQ-1 positions past rr_ptr; the first valid index wins.
  always_comb begin
    w_found    = 1'b0;
    w_winner   = '0;
    w_grant_oh = '0;
    w_idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && (i == w_idx) && req_valid[i]) begin
          w_found       = 1'b1;
          w_winner      = ID_W'(i);
          w_grant_oh[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    w_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_oh[i]) begin
        w_a = req_a[i*WIDTH +: WIDTH];
        w_b = req_b[i*WIDTH +: WIDTH];
        w_c = req_c[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_next_ptr = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_id_cap   <= '0;
      r_a_cap    <= '0;
      r_c_cap    <= '0;
      r_mid      <= '0;
      r_rsp_id   <= '0;
      r_rsp_and3 <= '0;
      r_rsp_mix  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id_cap <= w_winner;
            r_a_cap  <= w_a;
            r_c_cap  <= w_c;
            r_mid    <= w_a & w_b;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_rsp_and3 <= r_mid & r_c_cap;
          r_rsp_mix  <= r_mid | r_a_cap;
          r_rsp_id   <= r_id_cap;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          // Always return through IDLE so arbitration sees a fresh pointer.
          if (rsp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE) ? w_grant_oh : '0;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_and3  = r_rsp_and3;
  assign rsp_mix   = r_rsp_mix;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Directed bench for gate_eval_arbiter: reset, single op, backpressure,
// wrap/skip, reset in RESP and EVAL, and round-robin fairness.
module tb_gate_eval_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int ID_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*WIDTH-1:0] req_c;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_and3;
  logic [WIDTH-1:0]         rsp_mix;
  logic                     busy;
  logic [1:0]               dbg_state;

  int tests  = 0;
  int failed = 0;

  gate_eval_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_and3(rsp_and3), .rsp_mix(rsp_mix),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_c[i*WIDTH +: WIDTH] = c;
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [7:0] and3, input logic [7:0] mix);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, id);
    chk({tag, "_and3"}, rsp_and3, and3);
    chk({tag, "_mix"}, rsp_mix, mix);
  endtask

  logic [7:0] fa [4] = '{8'h96, 8'h5A, 8'hE7, 8'h3C};
  logic [7:0] fb [4] = '{8'h0F, 8'hF0, 8'hFF, 8'h66};
  logic [7:0] fc [4] = '{8'hFF, 8'h33, 8'h81, 8'hC3};

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_c = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("por_rsp_valid", rsp_valid, 0);
    chk("por_busy", busy, 0);
    chk("por_req_ready", req_ready, 0);
    chk("por_rsp_id", rsp_id, 0);
    chk("por_and3", rsp_and3, 0);
    chk("por_mix", rsp_mix, 0);

    // Single op from requester 1.
    set_ops(1, 8'hF0, 8'hCC, 8'hAA);
    req_valid = 4'b0010; rsp_ready = 1'b1;
    #1;
    chk("single_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    #1;
    chk("single_eval_state", dbg_state, 1);
    chk("single_eval_busy", busy, 1);
    chk("single_eval_rsp_valid", rsp_valid, 0);
    tick();
    chk("single_resp_state", dbg_state, 2);
    chk_rsp("single", 2'd1, 8'h80, 8'hF0);
    tick();
    chk("single_idle_busy", busy, 0);
    chk("single_idle_rsp_valid", rsp_valid, 0);

    // Backpressure: rr_ptr=2, requester 3 wins the search.
    set_ops(3, 8'h3C, 8'h0F, 8'hFF);
    set_ops(0, 8'h55, 8'hFF, 8'h0F);
    req_valid = 4'b1000; rsp_ready = 1'b0;
    #1;
    chk("bp_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'b0001;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk_rsp("bp_hold", 2'd3, 8'h0C, 8'h3C);
      chk("bp_hold_req_ready", req_ready, 0);
      chk("bp_hold_busy", busy, 1);
      tick();
    end
    chk_rsp("bp_last", 2'd3, 8'h0C, 8'h3C);
    rsp_ready = 1'b1;
    tick();
    chk("bp_release_state", dbg_state, 0);
    chk("bp_next_grant_wrap", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    chk_rsp("bp_next", 2'd0, 8'h05, 8'h55);
    tick();

    // Wrap and skip: rr_ptr=1, only 3 and 0 valid.
    set_ops(3, 8'hFF, 8'h81, 8'h01);
    set_ops(0, 8'h0F, 8'h3C, 8'hFF);
    req_valid = 4'b1001;
    #1;
    chk("wrap_first", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0001;
    tick();
    chk_rsp("wrap_r3", 2'd3, 8'h01, 8'hFF);
    tick();
    chk("wrap_second", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    tick();
    chk_rsp("wrap_r0", 2'd0, 8'h0C, 8'h0F);
    tick();
    req_valid = 4'b1111;
    #1;
    chk("wrap_ptr_is_1", req_ready, 4'b0010);
    req_valid = '0;
    #1;
    chk("drop_valid_no_grant", req_ready, 0);

    // Reset during RESP; grant to 2 first leaves rr_ptr=3 if reset were ignored.
    set_ops(2, 8'h12, 8'h34, 8'h56);
    req_valid = 4'b0100; rsp_ready = 1'b0;
    #1;
    chk("rst_setup_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    chk("rst_setup_resp", rsp_valid, 1);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_resp_rsp_valid", rsp_valid, 0);
    chk("rst_resp_busy", busy, 0);
    chk("rst_resp_req_ready", req_ready, 0);
    chk("rst_resp_and3", rsp_and3, 0);
    set_ops(2, 8'hAA, 8'hF0, 8'h3C);
    req_valid = 4'b1100; rsp_ready = 1'b1;
    #1;
    chk("rst_resp_first_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    chk_rsp("rst_resp_op", 2'd2, 8'h20, 8'hAA);
    tick();

    // Reset during EVAL: op from requester 1 (rr_ptr=3 -> search 3,0,1).
    set_ops(1, 8'hFF, 8'hFF, 8'hFF);
    req_valid = 4'b0010;
    #1;
    chk("eval_rst_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    chk("eval_rst_in_eval", dbg_state, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int n = 0; n < 3; n++) begin
      chk("eval_rst_no_rsp", rsp_valid, 0);
      chk("eval_rst_busy", busy, 0);
      tick();
    end

    // Fairness from rr_ptr=0 with all requesters continuously valid.
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, fa[i], fb[i], fc[i]);
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % NUM_REQ;
      chk("fair_grant", req_ready, 32'(1) << g);
      tick();
      chk("fair_eval_no_ready", req_ready, 0);
      tick();
      chk_rsp("fair", 2'(g), fa[g] & fb[g] & fc[g], (fa[g] & fb[g]) | fa[g]);
      tick();
    end
    req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
